// File: rtl/ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ctrl_pkg                                                              |
// | Control-word width, field bit indices and fixed register numbers.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ctrl_pkg;

    localparam int CTRL_W = 22;

    localparam int BIT_COND     = 21;
    localparam int BIT_R31      = 20;
    localparam int BIT_UJMP     = 19;
    localparam int BIT_DEST     = 18;
    localparam int SRC_HI       = 17;
    localparam int SRC_LO       = 15;
    localparam int ALU_HI       = 14;
    localparam int ALU_LO       = 11;
    localparam int BIT_LOAD     = 10;
    localparam int BIT_RF_EN    = 9;
    localparam int BIT_B_INSTR  = 8;
    localparam int BIT_TA_INSTR = 7;
    localparam int MSIZE_HI     = 6;
    localparam int MSIZE_LO     = 5;
    localparam int BIT_MEM_RW   = 4;
    localparam int BIT_MEM_SE   = 3;
    localparam int BIT_EN_HI    = 2;
    localparam int BIT_EN_LO    = 1;
    localparam int BIT_MEM_EN   = 0;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_stage_regs_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ctrl_pipe_stage_regs_if                                               |
// | ID-side inputs and EX/MEM/WB control outputs of the pipe stage block. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface ctrl_pipe_stage_regs_if #(
    parameter int CNT_W = 16
);
    import ctrl_pkg::*;

    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_instr;
    logic              stall;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_dest;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [4:0]        mem_dest;
    logic              wb_rf_enable;
    logic              wb_load;
    logic [4:0]        wb_dest;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_ctrl, id_instr,
        input  stall, ex_ctrl, ex_dest, mem_ctrl, mem_dest,
               wb_rf_enable, wb_load, wb_dest, stall_count
    );

    modport slave (
        input  id_ctrl, id_instr,
        output stall, ex_ctrl, ex_dest, mem_ctrl, mem_dest,
               wb_rf_enable, wb_load, wb_dest, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_use_detect                                                       |
// | Combinational load-use hazard check between EX and ID.                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module load_use_detect
    import ctrl_pkg::*;
(
    input  wire logic [CTRL_W-1:0] i_ex_ctrl,
    input  wire logic [4:0]        i_ex_dest,
    input  wire logic [CTRL_W-1:0] i_id_ctrl,
    input  wire logic [31:0]       i_id_instr,
    output logic                   o_stall
);

    logic       w_ex_load;
    logic       w_id_valid;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_unused;

    assign w_rs       = i_id_instr[25:21];
    assign w_rt       = i_id_instr[20:16];
    assign w_ex_load  = i_ex_ctrl[BIT_LOAD] & i_ex_ctrl[BIT_MEM_EN];
    assign w_id_valid = |i_id_ctrl;

    // rt is only a source operand when the instruction does not write it
    assign w_rs_hit = (i_ex_dest == w_rs);
    assign w_rt_hit = ~i_id_ctrl[BIT_R31] & (i_ex_dest == w_rt);

    assign o_stall = w_ex_load & (i_ex_dest != 5'd0) & w_id_valid
                   & (w_rs_hit | w_rt_hit);

    assign w_unused = ^{i_ex_ctrl[CTRL_W-1:BIT_LOAD+1],
                        i_ex_ctrl[BIT_LOAD-1:BIT_MEM_EN+1],
                        i_id_instr[31:26], i_id_instr[15:0]};

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_stage_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ctrl_pipe_stage_regs                                                  |
// | EX/MEM/WB control and destination registers, load-use stall, counter. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ctrl_pipe_stage_regs #(
    parameter int CTRL_W = 22,
    parameter int CNT_W  = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    ctrl_pipe_stage_regs_if.slave bus
);
    import ctrl_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_stall;
    logic [4:0]        w_id_dest;
    logic              w_cnt_sat;

    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [4:0]        r_ex_dest;
    logic [CTRL_W-1:0] r_mem_ctrl;
    logic [4:0]        r_mem_dest;
    logic              r_wb_rf_enable;
    logic              r_wb_load;
    logic [4:0]        r_wb_dest;
    logic [CNT_W-1:0]  r_stall_count;

    load_use_detect u_load_use_detect (
        .i_ex_ctrl  (r_ex_ctrl),
        .i_ex_dest  (r_ex_dest),
        .i_id_ctrl  (bus.id_ctrl),
        .i_id_instr (bus.id_instr),
        .o_stall    (w_stall)
    );

    always_comb begin
        w_id_dest = bus.id_instr[15:11];
        if (bus.id_ctrl[BIT_UJMP] && bus.id_ctrl[BIT_R31]) begin
            w_id_dest = REG_RA;
        end else if (bus.id_ctrl[BIT_R31]) begin
            w_id_dest = bus.id_instr[20:16];
        end
    end

    assign w_cnt_sat = &r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl      <= '0;
            r_ex_dest      <= '0;
            r_mem_ctrl     <= '0;
            r_mem_dest     <= '0;
            r_wb_rf_enable <= 1'b0;
            r_wb_load      <= 1'b0;
            r_wb_dest      <= '0;
            r_stall_count  <= '0;
        end else begin
            // A stall drops a bubble into EX; the held ID word retries next cycle
            if (w_stall) begin
                r_ex_ctrl <= '0;
                r_ex_dest <= '0;
            end else begin
                r_ex_ctrl <= bus.id_ctrl;
                r_ex_dest <= w_id_dest;
            end
            r_mem_ctrl     <= r_ex_ctrl;
            r_mem_dest     <= r_ex_dest;
            r_wb_rf_enable <= r_mem_ctrl[BIT_RF_EN];
            r_wb_load      <= r_mem_ctrl[BIT_LOAD];
            r_wb_dest      <= r_mem_dest;
            if (w_stall && !w_cnt_sat) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.ex_dest      = r_ex_dest;
    assign bus.mem_ctrl     = r_mem_ctrl;
    assign bus.mem_dest     = r_mem_dest;
    assign bus.wb_rf_enable = r_wb_rf_enable;
    assign bus.wb_load      = r_wb_load;
    assign bus.wb_dest      = r_wb_dest;
    assign bus.stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_stage_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ctrl_pipe_stage_regs                                               |
// | Directed stimulus with a cycle-tagged expectation scoreboard.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ctrl_pipe_stage_regs;

    // Narrow counter keeps the saturation run short; the logic is width-generic
    localparam int TB_CNT_W = 8;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    localparam logic [31:0] C_ADDIU = 32'h0010_8200;
    localparam logic [31:0] C_LBU   = 32'h0010_8601;
    localparam logic [31:0] C_SUBU  = 32'h0000_1A00;
    localparam logic [31:0] C_JAL   = 32'h0038_0200;
    localparam logic [31:0] C_LUI   = 32'h0011_5200;

    localparam int S_STALL = 0, S_EXC = 1, S_EXD = 2, S_MEMC = 3, S_MEMD = 4;
    localparam int S_WBRF = 5, S_WBLD = 6, S_WBD = 7, S_CNT = 8;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    bit   fin_req = 1'b0;
    bit   fin_done = 1'b0;
    exp_t sb[$];

    ctrl_pipe_stage_regs_if #(.CNT_W(TB_CNT_W)) bus ();

    ctrl_pipe_stage_regs #(.CTRL_W(22), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_STALL: actual = {31'd0, bus.stall};
            S_EXC:   actual = {10'd0, bus.ex_ctrl};
            S_EXD:   actual = {27'd0, bus.ex_dest};
            S_MEMC:  actual = {10'd0, bus.mem_ctrl};
            S_MEMD:  actual = {27'd0, bus.mem_dest};
            S_WBRF:  actual = {31'd0, bus.wb_rf_enable};
            S_WBLD:  actual = {31'd0, bus.wb_load};
            S_WBD:   actual = {27'd0, bus.wb_dest};
            default: actual = {24'd0, bus.stall_count};
        endcase
    endfunction

    function automatic string sname(input int sig);
        case (sig)
            S_STALL: sname = "stall";
            S_EXC:   sname = "ex_ctrl";
            S_EXD:   sname = "ex_dest";
            S_MEMC:  sname = "mem_ctrl";
            S_MEMD:  sname = "mem_dest";
            S_WBRF:  sname = "wb_rf_enable";
            S_WBLD:  sname = "wb_load";
            S_WBD:   sname = "wb_dest";
            default: sname = "stall_count";
        endcase
    endfunction

    // Monitor: compares every expectation tagged with the current cycle
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = actual(sb[i].sig);
                n_checks++;
                if (got === sb[i].exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d got=%h exp=%h",
                             sname(sb[i].sig), cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (fin_req && !fin_done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_pass++;
            end else begin
                $display("FAIL scoreboard_drain cyc=%0d got=%0d pending exp=0",
                         cyc, sb.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic push(input int c, input int sig, input logic [31:0] e);
        exp_t x;
        x.cyc = c;
        x.sig = sig;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_zero(input int c);
        for (int s = S_STALL; s <= S_CNT; s++) push(c, s, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one ID word; a stalled word is held for one extra cycle
    task automatic issue(input logic [31:0] ctrl, input logic [31:0] instr,
                         input logic [4:0] dest, input bit exp_stall);
        tick();
        bus.id_ctrl  = ctrl[21:0];
        bus.id_instr = instr;
        push(cyc, S_STALL, {31'd0, exp_stall});
        if (exp_stall) begin
            if (exp_cnt != CNT_MAX) exp_cnt++;
            push(cyc + 1, S_EXC, 32'd0);
            push(cyc + 1, S_EXD, 32'd0);
            push(cyc + 1, S_CNT, exp_cnt);
            push(cyc + 2, S_MEMC, 32'd0);
            tick();
            push(cyc, S_STALL, 32'd0);
        end else begin
            push(cyc + 1, S_CNT, exp_cnt);
        end
        push(cyc + 1, S_EXC, ctrl);
        push(cyc + 1, S_EXD, {27'd0, dest});
        push(cyc + 2, S_MEMC, ctrl);
        push(cyc + 2, S_MEMD, {27'd0, dest});
        push(cyc + 3, S_WBRF, {31'd0, ctrl[9]});
        push(cyc + 3, S_WBLD, {31'd0, ctrl[10]});
        push(cyc + 3, S_WBD, {27'd0, dest});
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.id_ctrl  = '0;
        bus.id_instr = '0;
        tick();
        tick();
        push_zero(cyc);
        reset = 1'b0;

        // ADDIU $5,$0,7 through all stages
        issue(C_ADDIU, 32'h2405_0007, 5'd5, 1'b0);
        nops(3);

        // LBU $3,0($4) then SUBU $6,$3,$2 (rs hit)
        issue(C_LBU, 32'h9083_0000, 5'd3, 1'b0);
        issue(C_SUBU, 32'h0062_3023, 5'd6, 1'b1);
        // LBU $3 then SUBU $6,$2,$3 (rt hit)
        issue(C_LBU, 32'h9083_0000, 5'd3, 1'b0);
        issue(C_SUBU, 32'h0043_3023, 5'd6, 1'b1);
        // ADDIU $3,$0,1 writes rt, so rt is not a source
        issue(C_LBU, 32'h9083_0000, 5'd3, 1'b0);
        issue(C_ADDIU, 32'h2403_0001, 5'd3, 1'b0);
        // NOP control word with rs=3 never stalls
        issue(C_LBU, 32'h9083_0000, 5'd3, 1'b0);
        issue(32'd0, 32'h0060_0000, 5'd0, 1'b0);
        // LBU $0 then reader of $0
        issue(C_LBU, 32'h9080_0000, 5'd0, 1'b0);
        issue(C_SUBU, 32'h0000_3823, 5'd7, 1'b0);
        // Destination select: JAL, LUI (rt), SUBU (rd)
        issue(C_JAL, 32'h0C00_0010, 5'd31, 1'b0);
        issue(C_LUI, 32'h3C09_1234, 5'd9, 1'b0);
        issue(C_SUBU, 32'h0022_3823, 5'd7, 1'b0);
        nops(3);

        // Reset with LBU in MEM and ADDIU in EX
        tick();
        bus.id_ctrl  = C_LBU[21:0];
        bus.id_instr = 32'h9083_0000;
        tick();
        bus.id_ctrl  = C_ADDIU[21:0];
        bus.id_instr = 32'h2405_0007;
        tick();
        push(cyc, S_EXD, 32'd5);
        push(cyc, S_MEMD, 32'd3);
        push(cyc, S_MEMC, C_LBU);
        bus.id_ctrl  = '0;
        bus.id_instr = '0;
        reset        = 1'b1;
        tick();
        push_zero(cyc);
        exp_cnt = 0;
        reset   = 1'b0;

        // Saturation: LBU $3,0($3) repeatedly depends on the previous load
        issue(C_LBU, 32'h9083_0000, 5'd3, 1'b0);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            issue(C_LBU, 32'h9063_0000, 5'd3, 1'b1);
        end
        nops(4);

        for (int i = 0; i < 4; i++) tick();
        fin_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
